// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 general register file: selects/formats the W-stage value,
// commits it on the clock edge, and serves two write-through read ports. Define GRF_TRACE_EN for a commit trace.
module wb_regfile #(
    parameter logic [31:0] LINK_OFFSET = 32'd4,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] INSTR_W,
    input  logic [4:0]  RegWrite_W,
    input  logic [31:0] ALUOUT_W,
    input  logic [31:0] DMOUT_W,
    input  logic [31:0] PC4_W,
    input  logic [31:0] MDdata_W,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic        WE_W,
    output logic [31:0] WD_W
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MFLO    = 6'h12;

    typedef enum logic [1:0] {SRC_ALU, SRC_LOAD, SRC_LINK, SRC_MD} src_e;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        unused_instr;
    src_e        src;
    logic [31:0] regs [32];

    assign opcode       = INSTR_W[31:26];
    assign funct        = INSTR_W[5:0];
    assign unused_instr = ^INSTR_W[25:6];

    // Extract the addressed byte/halfword of the memory word and extend it.
    function automatic logic [31:0] format_load(input logic [5:0] op,
                                                input logic [31:0] word,
                                                input logic [1:0] off);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        case (off)
            2'd0:    byte_s = signed'(word[7:0]);
            2'd1:    byte_s = signed'(word[15:8]);
            2'd2:    byte_s = signed'(word[23:16]);
            default: byte_s = signed'(word[31:24]);
        endcase
        half_s = off[1] ? signed'(word[31:16]) : signed'(word[15:0]);
        case (op)
            OP_LB:   format_load = 32'(byte_s);
            OP_LBU:  format_load = {24'b0, byte_s};
            OP_LH:   format_load = 32'(half_s);
            OP_LHU:  format_load = {16'b0, half_s};
            default: format_load = word;
        endcase
    endfunction

    always_comb begin
        src = SRC_ALU;
        case (opcode)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: src = SRC_LOAD;
            OP_JAL:                              src = SRC_LINK;
            OP_SPECIAL: begin
                if (funct == FN_JALR)
                    src = SRC_LINK;
                else if (funct == FN_MFHI || funct == FN_MFLO)
                    src = SRC_MD;
            end
            default: ;
        endcase
    end

    always_comb begin
        WD_W = ALUOUT_W;
        case (src)
            SRC_LOAD: WD_W = format_load(opcode, DMOUT_W, ALUOUT_W[1:0]);
            SRC_LINK: WD_W = PC4_W + LINK_OFFSET;
            SRC_MD:   WD_W = MDdata_W;
            default:  WD_W = ALUOUT_W;
        endcase
    end

    // Gating with reset also suppresses write-through while reset is held.
    assign WE_W = (RegWrite_W != 5'd0) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= RESET_VAL;
        end else if (WE_W) begin
            regs[RegWrite_W] <= WD_W;
        end
    end

    always_comb begin
        if (A1 == 5'd0)
            RD1 = 32'd0;
        else if (WE_W && A1 == RegWrite_W)
            RD1 = WD_W;
        else
            RD1 = regs[A1];

        if (A2 == 5'd0)
            RD2 = 32'd0;
        else if (WE_W && A2 == RegWrite_W)
            RD2 = WD_W;
        else
            RD2 = regs[A2];
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (WE_W)
            $display("@%h: $%d <= %h", PC4_W - 32'd4, RegWrite_W, WD_W);
    end
`else
`endif

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage plus general register file for the 5-stage MIPS pipeline.
- Consumes the M/W pipeline register outputs: instruction, destination number, ALU result, raw memory word, PC+4 and HI/LO data.
- Selects and formats the writeback value, then commits it to a 32x32 register file on the clock edge.
- Provides two combinational read ports with write-through for the D stage, and the W-stage write value for the forwarding network.

Parameters:
- LINK_OFFSET, 4, added to PC4_W to form the link value for jal/jalr (PC+8).
- RESET_VAL, 32'h0000_0000, value loaded into every register on reset.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- INSTR_W  input  32  instruction in W stage; 0 = bubble.
- RegWrite_W  input  5  destination register number; 0 = no write.
- ALUOUT_W  input  32  ALU result; bits [1:0] give the load byte offset.
- DMOUT_W  input  32  raw aligned data-memory word, unextended.
- PC4_W  input  32  PC+4 of the W instruction.
- MDdata_W  input  32  HI or LO value for mfhi/mflo.
- A1  input  5  read address, port 1.
- A2  input  5  read address, port 2.
- RD1  output  32  read data, port 1.
- RD2  output  32  read data, port 2.
- WE_W  output  1  write actually happening this cycle.
- WD_W  output  32  formatted writeback value, used for forwarding.

Behaviour:
- Clocking: clock clk; reset is synchronous and active-high. On a reset posedge all 32 registers load RESET_VAL.
- Decode of INSTR_W: opcode = [31:26], funct = [5:0].
- Source select, priority top-down:
  - lb/lbu/lh/lhu/lw (op 20,24,21,25,23 hex) -> LOAD.
  - jal (op 03), or jalr (op 00, funct 09) -> LINK.
  - mfhi/mflo (op 00, funct 10/12) -> MD.
  - Anything else -> ALU.
- Source values:
  - LINK = PC4_W + LINK_OFFSET, mod 2^32.
  - MD = MDdata_W.
  - ALU = ALUOUT_W.
- LOAD formatting, with off = ALUOUT_W[1:0]:
  - lw: DMOUT_W as-is.
  - lb/lbu: byte DMOUT_W[8*off+7:8*off], sign- or zero-extended.
  - lh/lhu: halfword selected by off[1], sign- or zero-extended; off[0] ignored.
- WE_W = (RegWrite_W != 0) and not reset.
- WD_W is combinational from the current inputs; it is valid even when WE_W = 0.
- Commit: at posedge with WE_W = 1, reg[RegWrite_W] <= WD_W. Write latency 1 cycle.
- Register 0: never written, always reads 0, even if RegWrite_W = 0 with a valid INSTR_W.
- Reads, combinational, with internal write-through: RDn = 0 if An = 0; else WD_W if WE_W and An == RegWrite_W; else reg[An].
- Simultaneous: A1 == A2 == RegWrite_W returns WD_W on both ports in the same cycle.
- Reset mid-operation: reset wins over a pending write, and write-through is suppressed while reset = 1.
- Bubble: INSTR_W = 0 with RegWrite_W = 0 -> no state change.
- Outputs during/after reset: RD1/RD2 = RESET_VAL for nonzero addresses (0 for address 0); WE_W = 0.

Optional Feature:
- GRF_TRACE_EN defined: each committing posedge prints "@%h: $%d <= %h" with PC (PC4_W-4), RegWrite_W and WD_W. Simulation only; no effect on outputs.
- GRF_TRACE_EN undefined: no print statements are compiled.

Test Plan:
- Reset held 1 cycle, then A1=5, A2=31 -> RD1=0, RD2=0, WE_W=0.
- ALU writeback: op 00 funct 21 (addu), RegWrite_W=8, ALUOUT_W=1234_5678 -> same-cycle write-through RD1 at A1=8 = 1234_5678; after the edge, persists with the inputs removed.
- Load extension: DMOUT_W=80FF_7F01 →
  - lb off=3 -> FFFF_FF80.
  - lbu off=2 -> 0000_00FF.
  - lh off=2 -> FFFF_80FF.
  - lhu off=0 -> 0000_7F01.
  - lw -> 80FF_7F01.
- Link: jal, RegWrite_W=31, PC4_W=0000_3004 -> WD_W = 0000_3008 and reg31 = 0000_3008.
- mflo, RegWrite_W=9, MDdata_W=DEAD_BEEF -> reg9 = DEAD_BEEF.
- Write to register 0 with ALUOUT_W=FFFF_FFFF -> RD1 at A1=0 = 0 and WE_W=0.
- Reset asserted together with a write to reg 4 -> reg4 = RESET_VAL.
